// File: rtl/tproj_arbiter.sv
// tproj_arbiter: round-robin merge of NREQ projection streams into one FIFO.
// Each bunch crossing gets one header word, followed by at most MAX_PROJ
// kept data words; overflow and reserved-code words are consumed and counted.
module tproj_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_PROJ = 64,
  parameter int DROP_W   = 8
) (
  input  logic                 proc_clk,
  input  logic                 reset,
  input  logic                 bx_start,
  input  logic [2:0]           bx,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*55-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 fifo_full,
  output logic [54:0]          out_data,
  output logic                 out_wr_en,
  output logic [6:0]           proj_count,
  output logic [DROP_W-1:0]    drop_count,
  output logic                 busy
);

  localparam int DATA_W = 55;
  localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, HDR, ARB} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_bx;
  logic [2:0]          w_bx_nxt;
  logic                w_hdr_wr;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       w_ptr_nxt;
  logic [NREQ-1:0]     w_grant;
  logic [DATA_W-1:0]   w_word;
  logic                w_hs;
  logic                w_keep;
  logic                w_drop;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_wr_en;
  logic [6:0]          r_proj_count;
  logic [DROP_W-1:0]   r_drop_count;

  // Round-robin search from the pointer; grants only in ARB with FIFO room.
  always_comb begin
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    w_grant   = '0;
    w_word    = '0;
    w_ptr_nxt = r_ptr;
    if (r_state == ARB && !fifo_full) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(r_ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && req_valid[idx]) begin
          found        = 1'b1;
          w_grant[idx] = 1'b1;
          w_word       = req_data[idx*DATA_W +: DATA_W];
          w_ptr_nxt    = (idx + 1 >= NREQ) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

  assign w_hs   = |w_grant;
  assign w_keep = w_hs && (r_proj_count < 7'(MAX_PROJ)) && (w_word[54:51] != 4'hF);
  assign w_drop = w_hs && !w_keep;

  // Next-state logic; a bx_start in HDR defers the header so only the newest BX is written.
  always_comb begin
    w_state_nxt = r_state;
    w_bx_nxt    = r_bx;
    w_hdr_wr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bx_start) begin
          w_bx_nxt    = bx;
          w_state_nxt = HDR;
        end
      end
      HDR: begin
        if (bx_start) begin
          w_bx_nxt = bx;
        end else if (!fifo_full) begin
          w_hdr_wr    = 1'b1;
          w_state_nxt = ARB;
        end
      end
      ARB: begin
        if (bx_start) begin
          w_bx_nxt    = bx;
          w_state_nxt = HDR;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, latched BX and round-robin pointer.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_bx    <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bx    <= w_bx_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Registered FIFO write port and per-BX / drop counters.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      r_out_data   <= '0;
      r_out_wr_en  <= 1'b0;
      r_proj_count <= '0;
      r_drop_count <= '0;
    end else begin
      r_out_wr_en <= w_hdr_wr | w_keep;
      if (w_hdr_wr) begin
        r_out_data   <= {4'hF, r_bx, 48'h0};
        r_proj_count <= '0;
      end else if (w_keep) begin
        r_out_data   <= w_word;
        r_proj_count <= r_proj_count + 7'd1;
      end
      if (w_drop && (r_drop_count != {DROP_W{1'b1}}))
        r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign req_ready  = w_grant;
  assign out_data   = r_out_data;
  assign out_wr_en  = r_out_wr_en;
  assign proj_count = r_proj_count;
  assign drop_count = r_drop_count;
  assign busy       = (r_state != IDLE);

endmodule

// File: doc/tproj_arbiter.md
Name: tproj_arbiter

Overview:
Shares a single projection output FIFO between NREQ tracklet-projection requesters. Per bunch crossing it emits one BX header word, then merges requester projections with round-robin arbitration. Each BX is capped at MAX_PROJ projections; excess words are dropped and counted. Sits between the projection calculators and the projection output FIFO, and drives that FIFO's din and wr_en.

Parameters:
NREQ, 4, number of requesters (2..8)
MAX_PROJ, 64, max data words written per BX (matches 6-bit per-BX write address)
DROP_W, 8, width of saturating drop counter

Ports:
proc_clk  in  1  processing clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
bx_start  in  1  single-cycle pulse marking start of a new BX
bx  in  3  BX number, sampled when bx_start=1
req_valid  in  NREQ  requester i has a projection word
req_data  in  NREQ*55  requester i word at bits [55*i+54 : 55*i]
req_ready  out  NREQ  one-hot grant, combinational; transfer when req_valid[i] & req_ready[i]
fifo_full  in  1  downstream programmable-full; asserted with at least 2 free entries left
out_data  out  55  word to FIFO din, registered
out_wr_en  out  1  FIFO wr_en, registered
proj_count  out  7  data words written in current BX (0..MAX_PROJ)
drop_count  out  DROP_W  dropped words since reset, saturating
busy  out  1  1 when state is not IDLE

Behaviour:
- Reset (synchronous): state=IDLE; rr pointer=0; out_data=0; out_wr_en=0; proj_count=0; drop_count=0; req_ready=0; latched BX=0.
- States: IDLE, HDR, ARB.
- IDLE: req_ready=0. On bx_start, latch bx and go to HDR.
- HDR: req_ready=0. If fifo_full=0, register out_data={4'hF, BX, 48'h0} with out_wr_en=1, clear proj_count, go to ARB. Otherwise hold in HDR.
- ARB: if fifo_full=1, req_ready=0. Otherwise grant the first i with req_valid[i]=1, searching from pointer upward and wrapping modulo NREQ. Exactly one req_ready bit is set, and none if no request.
- After a grant to i, pointer becomes (i+1) mod NREQ. Pointer is unchanged when there is no grant.
- Accepted word, normal case: when proj_count<MAX_PROJ and word[54:51]!=4'hF, the next cycle has out_data=word and out_wr_en=1, and proj_count increments. Latency is 1 cycle from handshake to wr_en.
- Accepted word, dropped case: when proj_count==MAX_PROJ, or word[54:51]==4'hF (reserved header code), the word is still consumed (ready asserted) so requesters drain. out_wr_en=0 and drop_count increments, saturating at 2^DROP_W-1.
- out_wr_en=0 on every cycle without a header write or accepted kept word. out_data holds its last value.
- bx_start while in ARB: a handshake in that same cycle completes normally. BX is latched and the next state is HDR.
- bx_start while in HDR: BX is overwritten with the newest value and the state stays HDR. Only one header is written.
- ARB never returns to IDLE; only reset does.
- Reset mid-operation returns to the reset state on the next edge. Any pending transfer is lost and no partial write is issued.
- fifo_full is sampled combinationally for grant. The 2-entry slack covers the registered write.

Test Plan:
- Reset, then bx_start with bx=3 and fifo_full=0 -> next cycle out_wr_en=1 and out_data=55'h7B000000000000 (header for BX 3); proj_count=0.
- All 4 requesters held valid, 8 cycles in ARB -> req_ready sequence 0001,0010,0100,1000,0001,... and out_data follows the granted words with 1-cycle latency; proj_count=8.
- Requester 2 alone streams 70 words in one BX -> 64 writes then proj_count=64; remaining 6 consumed with out_wr_en=0; drop_count=6.
- fifo_full=1 during ARB with requests pending -> req_ready=0 and out_wr_en=0 on the following cycle; deassert fifo_full -> grants resume at the retained pointer.
- bx_start coinciding with grant of requester 1 in ARB -> that word is written, then a header with the new BX; proj_count resets to 0.
- reset asserted mid-stream -> next cycle all outputs 0, state IDLE; a subsequent bx_start restarts with a header.
